// File: rtl/flight_phase_sequencer_if.sv
// Bundle between the launch controller / height integrator and the flight
// phase sequencer. The master side supplies launch commands and the height
// stream; the slave side (the sequencer) returns phase and flight results.
// Handshake: height is consumed on any rising clk edge where height_valid=1;
// there is no back-pressure, the sequencer always accepts a valid sample.
interface flight_phase_sequencer_if #(
   parameter int N = 64
);
   logic         start;
   logic [N-1:0] burntime;
   logic [N-1:0] height;
   logic         height_valid;
   logic         start_integration;
   logic [2:0]   phase;
   logic         burnout;
   logic         apogee_valid;
   logic [N-1:0] elapsed_s;
   logic [N-1:0] max_height;
   logic [N-1:0] apogee_time;

   modport master (
      output start, burntime, height, height_valid,
      input  start_integration, phase, burnout, apogee_valid,
      input  elapsed_s, max_height, apogee_time
   );

   modport slave (
      input  start, burntime, height, height_valid,
      output start_integration, phase, burnout, apogee_valid,
      output elapsed_s, max_height, apogee_time
   );
endinterface

// File: rtl/flight_phase_sequencer.sv
// Flight phase sequencer: arms the integrator on launch, counts mission
// seconds, declares burnout at the latched burn time and confirms apogee
// after CONFIRM consecutive non-rising height samples. All outputs are
// registered; phase is the FSM state register itself.
module flight_phase_sequencer #(
   parameter int N           = 64,
   parameter int TICK_CYCLES = 50,
   parameter int CONFIRM     = 4
) (
   input  logic                        clk,
   input  logic                        resetb,
   flight_phase_sequencer_if.slave     bus
);
   localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam int FW = $clog2(CONFIRM + 1);
   localparam logic [PW-1:0] TICK_LAST = PW'(TICK_CYCLES - 1);
   localparam logic [FW-1:0] FALL_DONE = FW'(CONFIRM);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      BURN   = 3'd1,
      COAST  = 3'd2,
      APOGEE = 3'd3,
      DONE   = 3'd4
   } state_t;

   state_t        state, state_n;
   logic [PW-1:0] prescale, prescale_n;
   logic [N-1:0]  elapsed, elapsed_n;
   logic [N-1:0]  burn_lat, burn_lat_n;
   logic [N-1:0]  max_h, max_h_n;
   logic [N-1:0]  apo_t, apo_t_n;
   logic [FW-1:0] fall_cnt, fall_cnt_n;
   logic          start_int, start_int_n;
   logic          burnout, burnout_n;
   logic          apo_valid, apo_valid_n;

   logic          tick;
   logic          rising;
   logic [N-1:0]  elapsed_inc;
   logic [FW-1:0] fall_inc;

   assign tick        = (prescale == TICK_LAST);
   assign rising      = ($signed(bus.height) > $signed(max_h));
   assign elapsed_inc = (elapsed != {N{1'b1}}) ? elapsed + 1'b1 : elapsed;
   assign fall_inc    = fall_cnt + 1'b1;

   // Register all state; reset takes priority over every other event.
   always_ff @(posedge clk) begin
      if (resetb) begin
         state     <= IDLE;
         prescale  <= '0;
         elapsed   <= '0;
         burn_lat  <= '0;
         max_h     <= '0;
         apo_t     <= '0;
         fall_cnt  <= '0;
         start_int <= 1'b0;
         burnout   <= 1'b0;
         apo_valid <= 1'b0;
      end else begin
         state     <= state_n;
         prescale  <= prescale_n;
         elapsed   <= elapsed_n;
         burn_lat  <= burn_lat_n;
         max_h     <= max_h_n;
         apo_t     <= apo_t_n;
         fall_cnt  <= fall_cnt_n;
         start_int <= start_int_n;
         burnout   <= burnout_n;
         apo_valid <= apo_valid_n;
      end
   end

   // Next-state, timekeeping and height tracking.
   always_comb begin
      state_n     = state;
      prescale_n  = prescale;
      elapsed_n   = elapsed;
      burn_lat_n  = burn_lat;
      max_h_n     = max_h;
      apo_t_n     = apo_t;
      fall_cnt_n  = fall_cnt;
      start_int_n = start_int;
      burnout_n   = 1'b0;
      apo_valid_n = 1'b0;

      // Mission clock and height tracking only run while in flight.
      if (state == BURN || state == COAST) begin
         if (tick) begin
            prescale_n = '0;
            elapsed_n  = elapsed_inc;
         end else begin
            prescale_n = prescale + 1'b1;
         end
         if (bus.height_valid && rising) begin
            max_h_n    = bus.height;
            apo_t_n    = elapsed;
            fall_cnt_n = '0;
         end
      end

      case (state)
         IDLE, DONE: begin
            if (bus.start) begin
               state_n     = BURN;
               burn_lat_n  = bus.burntime;
               prescale_n  = '0;
               elapsed_n   = '0;
               max_h_n     = '0;
               apo_t_n     = '0;
               fall_cnt_n  = '0;
               start_int_n = 1'b1;
            end
         end
         BURN: begin
            if (burn_lat == '0 || (tick && elapsed_inc == burn_lat)) begin
               state_n   = COAST;
               burnout_n = 1'b1;
            end
         end
         COAST: begin
            if (bus.height_valid && !rising) begin
               fall_cnt_n = fall_inc;
               if (fall_inc == FALL_DONE) begin
                  state_n     = APOGEE;
                  apo_valid_n = 1'b1;
               end
            end
         end
         APOGEE: begin
            state_n     = DONE;
            start_int_n = 1'b0;
         end
         default: state_n = IDLE;
      endcase
   end

   assign bus.phase             = state;
   assign bus.start_integration = start_int;
   assign bus.burnout           = burnout;
   assign bus.apogee_valid      = apo_valid;
   assign bus.elapsed_s         = elapsed;
   assign bus.max_height        = max_h;
   assign bus.apogee_time       = apo_t;
endmodule

// File: tb/tb_flight_phase_sequencer.sv
// Directed bench for flight_phase_sequencer: burn timing, apogee confirmation,
// interrupted fall, zero burn time, negative heights, mid-flight reset.
module tb_flight_phase_sequencer;
   localparam int N = 64;

   logic clk;
   logic resetb;
   int   tests;
   int   fails;
   int   seen;

   flight_phase_sequencer_if #(.N(N)) bus ();

   flight_phase_sequencer #(.N(N), .TICK_CYCLES(50), .CONFIRM(4)) dut (
      .clk    (clk),
      .resetb (resetb),
      .bus    (bus.slave)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge; inputs change and outputs are sampled 1 time unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic feed(input logic [N-1:0] h);
      bus.height       = h;
      bus.height_valid = 1'b1;
      step();
   endtask

   initial begin
      tests = 0;
      fails = 0;
      resetb = 1'b1;
      bus.start = 1'b1;
      bus.burntime = '0;
      bus.height = '0;
      bus.height_valid = 1'b0;

      // Reset held 3 cycles with start asserted
      steps(3);
      check("rst_phase", N'(bus.phase), 0);
      check("rst_si", N'(bus.start_integration), 0);
      check("rst_burnout", N'(bus.burnout), 0);
      check("rst_apv", N'(bus.apogee_valid), 0);
      check("rst_elapsed", bus.elapsed_s, 0);
      check("rst_max", bus.max_height, 0);
      check("rst_apt", bus.apogee_time, 0);

      // Flight 1: burntime 168, interrupted fall in COAST
      resetb = 1'b0;
      bus.start = 1'b0;
      step();
      check("idle_phase", N'(bus.phase), 0);
      bus.burntime = 168;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      check("f1_phase_burn", N'(bus.phase), 1);
      check("f1_si", N'(bus.start_integration), 1);
      check("f1_elapsed0", bus.elapsed_s, 0);
      seen = 0;
      for (int i = 0; i < 8399; i++) begin
         step();
         if (bus.burnout !== 1'b0) seen++;
      end
      check("f1_no_early_burnout", N'(seen), 0);
      check("f1_still_burn", N'(bus.phase), 1);
      check("f1_elapsed167", bus.elapsed_s, 167);
      step();
      check("f1_burnout", N'(bus.burnout), 1);
      check("f1_phase_coast", N'(bus.phase), 2);
      check("f1_elapsed168", bus.elapsed_s, 168);
      step();
      check("f1_burnout_low", N'(bus.burnout), 0);
      check("f1_phase_coast2", N'(bus.phase), 2);

      feed(500);
      check("f1_max500", bus.max_height, 500);
      check("f1_apt500", bus.apogee_time, 168);
      feed(490);
      feed(480);
      check("f1_no_apv_480", N'(bus.apogee_valid), 0);
      feed(510);
      check("f1_max510", bus.max_height, 510);
      feed(505);
      feed(504);
      feed(503);
      check("f1_no_apv_503", N'(bus.apogee_valid), 0);
      check("f1_phase_503", N'(bus.phase), 2);
      feed(502);
      check("f1_apv", N'(bus.apogee_valid), 1);
      check("f1_phase_apogee", N'(bus.phase), 3);
      check("f1_max_final", bus.max_height, 510);
      check("f1_apt_final", bus.apogee_time, 168);
      bus.height_valid = 1'b0;
      step();
      check("f1_phase_done", N'(bus.phase), 4);
      check("f1_apv_low", N'(bus.apogee_valid), 0);
      check("f1_si_low", N'(bus.start_integration), 0);
      steps(5);
      check("f1_done_hold_max", bus.max_height, 510);
      check("f1_done_hold_elapsed", bus.elapsed_s, 168);

      // Flight 2: burntime 2, start ignored in BURN, apogee on plateau + fall
      bus.burntime = 2;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      check("f2_phase_burn", N'(bus.phase), 1);
      check("f2_si", N'(bus.start_integration), 1);
      check("f2_max_cleared", bus.max_height, 0);
      check("f2_apt_cleared", bus.apogee_time, 0);
      check("f2_elapsed_cleared", bus.elapsed_s, 0);
      steps(10);
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      steps(49);
      check("f2_start_ignored_elapsed", bus.elapsed_s, 1);
      check("f2_start_ignored_phase", N'(bus.phase), 1);
      steps(39);
      check("f2_prev_burn", N'(bus.phase), 1);
      step();
      check("f2_burnout", N'(bus.burnout), 1);
      check("f2_elapsed2", bus.elapsed_s, 2);
      feed(100);
      feed(200);
      feed(300);
      feed(300);
      feed(290);
      feed(280);
      check("f2_no_apv_280", N'(bus.apogee_valid), 0);
      feed(270);
      check("f2_apv", N'(bus.apogee_valid), 1);
      check("f2_phase_apogee", N'(bus.phase), 3);
      check("f2_max", bus.max_height, 300);
      check("f2_apt", bus.apogee_time, 2);
      bus.height_valid = 1'b0;
      step();
      check("f2_phase_done", N'(bus.phase), 4);
      check("f2_si_low", N'(bus.start_integration), 0);

      // Flight 3: burntime 0, no valid heights, then reset mid-COAST
      bus.burntime = 0;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      check("f3_phase_burn", N'(bus.phase), 1);
      step();
      check("f3_phase_coast", N'(bus.phase), 2);
      check("f3_burnout", N'(bus.burnout), 1);
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (bus.apogee_valid !== 1'b0) seen++;
      end
      check("f3_no_apogee_invalid", N'(seen), 0);
      check("f3_still_coast", N'(bus.phase), 2);
      feed(50);
      feed(40);
      feed(30);
      check("f3_max50", bus.max_height, 50);
      bus.height_valid = 1'b0;
      resetb = 1'b1;
      bus.start = 1'b1;
      step();
      resetb = 1'b0;
      bus.start = 1'b0;
      check("f3_rst_phase", N'(bus.phase), 0);
      check("f3_rst_max", bus.max_height, 0);
      check("f3_rst_apt", bus.apogee_time, 0);
      check("f3_rst_elapsed", bus.elapsed_s, 0);
      check("f3_rst_si", N'(bus.start_integration), 0);
      check("f3_rst_burnout", N'(bus.burnout), 0);

      // Flight 4: clean restart, heights never positive
      bus.burntime = 0;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      check("f4_phase_burn", N'(bus.phase), 1);
      step();
      check("f4_phase_coast", N'(bus.phase), 2);
      feed(-64'sd5);
      feed(-64'sd6);
      feed(-64'sd7);
      check("f4_no_apv", N'(bus.apogee_valid), 0);
      feed(-64'sd8);
      check("f4_apv", N'(bus.apogee_valid), 1);
      check("f4_max_zero", bus.max_height, 0);
      check("f4_apt_zero", bus.apogee_time, 0);
      bus.height_valid = 1'b0;
      step();
      check("f4_phase_done", N'(bus.phase), 4);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/flight_phase_sequencer.md
# flight_phase_sequencer

Sequencer for the trajectory pipeline: arms the velocity integrator, keeps mission time in whole seconds, declares burnout at the configured burn time, and detects apogee from the integrated height stream. It sits directly downstream of the height integrator, consuming its result. It supplies `start_integration` back to the integrator and publishes phase, burnout and apogee results to later telemetry stages.

## Interface
- `N`, 64, datapath width for time and height words
- `TICK_CYCLES`, 50, clock cycles per mission second (≥1)
- `CONFIRM`, 4, consecutive non-rising height samples required to declare apogee (≥1)
- `clk` in 1, single system clock, all logic on rising edge
- `resetb` in 1, reset; synchronous, active-high (1 = reset), sampled on `clk`
- `start` in 1, launch command; one-cycle pulse is sufficient
- `burntime` in N, burn duration in seconds, unsigned; sampled when `start` is accepted
- `height` in N, integrated height, signed two's complement, ×10^-3 m
- `height_valid` in 1, `height` is a new sample this cycle
- `start_integration` out 1, integrator enable
- `phase` out 3, 0 IDLE, 1 BURN, 2 COAST, 3 APOGEE, 4 DONE
- `burnout` out 1, one-cycle pulse on entry to COAST
- `apogee_valid` out 1, one-cycle pulse in APOGEE
- `elapsed_s` out N, seconds since launch, unsigned
- `max_height` out N, signed, largest height seen since launch
- `apogee_time` out N, `elapsed_s` value when `max_height` was captured

## Operation
- Reset values: `phase`=0, all other outputs 0. Internal counters, `fall_cnt` and the latched burntime are also 0.
- IDLE: `start`=1 → BURN. On the same edge:
  - latch `burntime`
  - clear `elapsed_s`, prescaler, `max_height`, `apogee_time`, `fall_cnt`
  - set `start_integration`=1
- Prescaler: counts 0..TICK_CYCLES-1 in BURN and COAST. On wrap, `elapsed_s` increments, saturating at 2^N-1. The prescaler is frozen in other states.
- BURN:
  - If latched burntime = 0, go to COAST on the next edge.
  - Otherwise go to COAST on the edge where `elapsed_s` becomes equal to burntime. The time increment and the transition happen on the same edge.
  - `burnout`=1 for exactly the first cycle in COAST.
- Height tracking, in BURN and COAST, only when `height_valid`=1:
  - Compare signed. If `height` > `max_height`: `max_height`←`height`, `apogee_time`←`elapsed_s` (pre-increment value on that edge), `fall_cnt`←0.
  - Otherwise, in COAST only, `fall_cnt`←`fall_cnt`+1.
  - In BURN the counter is held at 0.
- COAST → APOGEE on the edge where `fall_cnt` would reach CONFIRM. `fall_cnt` then holds.
- APOGEE: one cycle with `apogee_valid`=1, then unconditionally → DONE.
- DONE:
  - `start_integration`=0; results hold.
  - `start`=1 → BURN with a full re-arm, same as from IDLE.
- `start` in BURN, COAST or APOGEE is ignored.
- `height_valid`=0 leaves `max_height`, `apogee_time` and `fall_cnt` unchanged.
- A rising sample in COAST after a partial fall count resets `fall_cnt` to 0. A flat plateau counts as non-rising.
- Reset mid-operation wins over every other event: on the next edge all outputs take their reset values.
- `max_height` starts at 0, so a flight whose height never goes positive still reports 0 / time 0 at apogee.

## Timing
- `start` sampled at edge k → `phase`=1 and `start_integration`=1 visible after edge k.
- First `elapsed_s` increment at edge k+TICK_CYCLES. Value s is reached at edge k+s·TICK_CYCLES.
- Burnout with burntime B≥1: `phase`=2 and `burnout`=1 after edge k+B·TICK_CYCLES; `burnout` is low after the following edge.
- Burntime 0: COAST at edge k+1.
- Apogee: if the CONFIRM-th consecutive non-rising sample is sampled at edge m:
  - `phase`=3 and `apogee_valid`=1 after edge m
  - `phase`=4 after edge m+1
  - `start_integration` low after edge m+1
- All outputs are registered. No combinational path from input to output.

## Test plan
- Reset: hold `resetb`=1 for 3 cycles with `start`=1 → all outputs 0, `phase`=0.
- Burn timing (TICK_CYCLES=50, burntime=168): pulse `start` → `phase`=1 next cycle; `burnout` exactly one cycle at 8400 cycles after start; `elapsed_s`=168 at that point.
- Apogee (CONFIRM=4, burntime=2): after burnout, feed heights 100, 200, 300, 300, 290, 280, 270 with `height_valid`=1 each cycle → `apogee_valid` pulse after the 270 sample; `max_height`=300; `apogee_time`=time of the first 300 sample; `phase`=4 the next cycle.
- Fall interrupted: in COAST feed 500, 490, 480, 510, 505, 504, 503, 502 → no apogee until after 502; `max_height`=510.
- Burntime 0 with `height_valid`=0: pulse `start` → `burnout` at start+2 cycles; no apogee while valid stays low.
- Reset mid-COAST: assert `resetb` during a falling sequence → IDLE with zeroed outputs next edge. A subsequent `start` re-runs cleanly; `start` pulsed during BURN is ignored (`elapsed_s` not cleared).
